paced_ring_fifo: RTL and testbench
==================================

Name: paced_ring_fifo

Overview:
- Circular-buffer FIFO with independent valid/ready handshakes on input and output. It replaces the shift-register queue in the rendering pipeline.
- Parametrised in depth and width; depth need not be a power of two.
- A minimum inter-beat gap paces the consumer, e.g. a rasteriser or pixel writer that cannot accept back-to-back words.
- Status outputs: occupancy count, empty, full and almost-full.

Parameters:
- DEPTH, 16, number of storage slots; must be >= 2; any integer.
- DATA_WIDTH, 64, bits per word.
- GAP, 0, minimum idle cycles after each output transfer before data_valid_out may reassert; 0 allows back-to-back beats.
- AF_THRESH, DEPTH-2, almost_full_out asserts when count_out >= AF_THRESH; must satisfy 1 <= AF_THRESH <= DEPTH.

Ports:
- clk_in  input  1  clock; all logic rising-edge.
- rst_in  input  1  asynchronous, active-high reset.
- data_valid_in  input  1  producer has a word on data_in.
- data_in  input  DATA_WIDTH  producer word.
- ready_out  input/output note: output  1  FIFO can accept a word this cycle; equals !full_out.
- data_out  output  DATA_WIDTH  head word; registered.
- data_valid_out  output  1  data_out holds a valid word; registered.
- receiver_ready  input  1  consumer accepts data_out this cycle.
- full_out  output  1  count_out == DEPTH.
- empty_out  output  1  count_out == 0.
- almost_full_out  output  1  count_out >= AF_THRESH.
- count_out  output  $clog2(DEPTH+1)  words held, including the one presented on data_out.

Behaviour:
- Reset (async assert; deassertion is synchronised by the top level):
  - count_out = 0, pointers = 0, data_out = 0, data_valid_out = 0, empty_out = 1, full_out = 0, almost_full_out = 0.
  - Gap counter = 0; state = EMPTY.
  - Reset mid-transfer discards all contents; no partial word survives.
- Push:
  - Occurs when data_valid_in && ready_out at the rising edge.
  - Word is written at wr_ptr; wr_ptr increments and wraps from DEPTH-1 to 0.
  - A push while full is ignored; the data is dropped and no state changes.
  - The producer must hold the word until ready_out is seen high.
- Pop:
  - Occurs when data_valid_out && receiver_ready at the rising edge.
  - rd_ptr advances with the same wrap rule.
- Simultaneous push and pop:
  - count_out is unchanged.
  - Allowed at any fill level except full. When full, ready_out = 0, so no push occurs and a pop that edge frees a slot for the next cycle. There is no same-cycle pass-through when full.
- count_out, full_out, empty_out and almost_full_out are registered and update on the edge of the push or pop.
- Output register:
  - data_out is loaded from rd_ptr when presenting.
  - data_out and data_valid_out are held stable while data_valid_out && !receiver_ready.
  - data_out is undefined-but-stable when data_valid_out = 0; it holds its last value.
- Latency: a word pushed into an empty FIFO with no gap pending appears with data_valid_out = 1 on the first edge after the push edge (1 cycle).
- State machine:
  - EMPTY: data_valid_out = 0. On push, go to PRESENT and load data_out.
  - PRESENT: data_valid_out = 1. Stay while !receiver_ready.
    - On pop with GAP = 0: go to PRESENT if any word remains, including one pushed that same cycle; otherwise EMPTY.
    - On pop with GAP > 0: go to COOL and load the gap counter with GAP-1.
  - COOL: data_valid_out = 0; gap counter decrements each cycle.
    - When the counter reaches 0: go to PRESENT if count_out > 0, else EMPTY.
    - Pushes are accepted during COOL.
- Pacing invariant: consecutive pops are at least GAP+1 cycles apart.
- Pointer widths are $clog2(DEPTH). Wrap uses compare-to-DEPTH-1, never modulo of a power of two.

Optional Feature:
- Macro: PACED_FIFO_ERR_FLAGS_EN.
- Defined: adds outputs overflow_out and underflow_out (1 bit each, reset 0). Both are sticky until reset.
  - overflow_out sets on data_valid_in while full_out.
  - underflow_out sets on receiver_ready while empty_out and in state EMPTY.
- Undefined: neither port exists; the dropped-push behaviour is unchanged.

Test Plan:
- Reset, then a single push of 0xA5 with receiver_ready = 1, GAP = 0:
  - data_valid_out high exactly one edge after the push with data_out = 0xA5.
  - count_out goes 0 -> 1 -> 0; empty_out returns to 1.
- DEPTH = 5: push 5 words with receiver_ready = 0:
  - full_out = 1, ready_out = 0, count_out = 5.
  - A 6th push is dropped (overflow_out = 1 if the macro is defined).
  - Draining yields the first 5 words in order.
- DEPTH = 5: stream 23 words with random valid/ready:
  - Output order exactly matches input order across 4+ pointer wraps.
  - count_out always equals pushes minus pops.
- GAP = 3, 4 words preloaded, receiver_ready held at 1:
  - Pops land on cycles t, t+4, t+8, t+12; data_valid_out is low for 3 cycles between each.
- Full FIFO with push and pop asserted on the same edge:
  - Pop completes, push is ignored, count_out = DEPTH-1.
  - Next cycle the push is accepted and count_out = DEPTH.
- Assert rst_in asynchronously mid-stream, between clock edges:
  - All outputs take their reset values immediately, without waiting for an edge.
  - After release, the first pushed word is the first popped word.

Source files
------------

// File: rtl/paced_ring_fifo.sv
// paced_ring_fifo: circular-buffer FIFO with valid/ready on both sides and a
// programmable minimum idle gap between output beats.
//
// Ports:
//   clk_in          rising-edge clock
//   rst_in          asynchronous active-high reset
//   data_valid_in   producer word valid
//   data_in         producer word
//   ready_out       FIFO can accept a word (equals !full_out)
//   data_out        registered head word
//   data_valid_out  registered head-word valid
//   receiver_ready  consumer accepts data_out this cycle
//   full_out        count_out == DEPTH
//   empty_out       count_out == 0
//   almost_full_out count_out >= AF_THRESH
//   count_out       words held, including the one shown on data_out
//
// Optional: define PACED_FIFO_ERR_FLAGS_EN to add sticky overflow_out and
// underflow_out flags.
module paced_ring_fifo #(
  parameter int DEPTH      = 16,
  parameter int DATA_WIDTH = 64,
  parameter int GAP        = 0,
  parameter int AF_THRESH  = DEPTH - 2
) (
  input  logic                         clk_in,
  input  logic                         rst_in,
  input  logic                         data_valid_in,
  input  logic [DATA_WIDTH-1:0]        data_in,
  output logic                         ready_out,
  output logic [DATA_WIDTH-1:0]        data_out,
  output logic                         data_valid_out,
  input  logic                         receiver_ready,
  output logic                         full_out,
  output logic                         empty_out,
  output logic                         almost_full_out,
  output logic [$clog2(DEPTH+1)-1:0]   count_out
`ifdef PACED_FIFO_ERR_FLAGS_EN
  ,
  output logic                         overflow_out,
  output logic                         underflow_out
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int GW = (GAP > 0) ? $clog2(GAP + 1) : 1;
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] AF_CNT   = CW'(AF_THRESH);
  localparam logic [GW-1:0] GAP_LOAD = (GAP > 0) ? GW'(GAP - 1) : '0;

  typedef enum logic [1:0] {StEmpty, StPresent, StCool} state_t;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]         wr_ptr, rd_ptr, wr_next, rd_next;
  logic [CW-1:0]         count_d;
  logic [GW-1:0]         gap_cnt;
  state_t                state;
  logic                  push, pop;

  assign ready_out = !full_out;
  assign push      = data_valid_in && ready_out;
  assign pop       = data_valid_out && receiver_ready;

  // Explicit wrap so non-power-of-two depths work.
  assign wr_next = (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
  assign rd_next = (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;

  always_comb begin
    count_d = count_out;
    unique case ({push, pop})
      2'b10:   count_d = count_out + 1'b1;
      2'b01:   count_d = count_out - 1'b1;
      default: count_d = count_out;
    endcase
  end

  // Storage needs no reset; pointers and count define what is valid.
  always_ff @(posedge clk_in) begin
    if (push) begin
      mem[wr_ptr] <= data_in;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      count_out       <= '0;
      full_out        <= 1'b0;
      empty_out       <= 1'b1;
      almost_full_out <= 1'b0;
      data_out        <= '0;
      data_valid_out  <= 1'b0;
      gap_cnt         <= '0;
      state           <= StEmpty;
    end else begin
      if (push) wr_ptr <= wr_next;
      if (pop)  rd_ptr <= rd_next;
      count_out       <= count_d;
      full_out        <= (count_d == FULL_CNT);
      empty_out       <= (count_d == '0);
      almost_full_out <= (count_d >= AF_CNT);

      case (state)
        StEmpty: begin
          // Count is always zero here, so the pushed word goes straight out.
          if (push) begin
            state          <= StPresent;
            data_valid_out <= 1'b1;
            data_out       <= data_in;
          end
        end
        StPresent: begin
          if (pop) begin
            if (GAP == 0) begin
              if (count_out > CW'(1)) begin
                data_out <= mem[rd_next];
              end else if (push) begin
                // Next word is being written this edge; bypass the array.
                data_out <= data_in;
              end else begin
                state          <= StEmpty;
                data_valid_out <= 1'b0;
              end
            end else begin
              state          <= StCool;
              data_valid_out <= 1'b0;
              gap_cnt        <= GAP_LOAD;
            end
          end
        end
        StCool: begin
          if (gap_cnt == '0) begin
            if (count_out != '0) begin
              state          <= StPresent;
              data_valid_out <= 1'b1;
              data_out       <= mem[rd_ptr];
            end else if (push) begin
              state          <= StPresent;
              data_valid_out <= 1'b1;
              data_out       <= data_in;
            end else begin
              state <= StEmpty;
            end
          end else begin
            gap_cnt <= gap_cnt - 1'b1;
          end
        end
        default: begin
          state          <= StEmpty;
          data_valid_out <= 1'b0;
        end
      endcase
    end
  end

`ifdef PACED_FIFO_ERR_FLAGS_EN
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      overflow_out  <= 1'b0;
      underflow_out <= 1'b0;
    end else begin
      if (data_valid_in && full_out) overflow_out <= 1'b1;
      if (receiver_ready && empty_out && (state == StEmpty)) underflow_out <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_paced_ring_fifo.sv
// tb_paced_ring_fifo: directed bench for paced_ring_fifo. Instance a uses
// DEPTH=5, GAP=0; instance b uses DEPTH=5, GAP=3. Inputs change and outputs
// are sampled on the falling clock edge.
module tb_paced_ring_fifo;

  localparam int DW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          a_vin, a_rdy, a_vout, a_rr, a_full, a_empty, a_af;
  logic [DW-1:0] a_din, a_dout;
  logic [2:0]    a_cnt;
  logic          b_vin, b_rdy, b_vout, b_rr, b_full, b_empty, b_af;
  logic [DW-1:0] b_din, b_dout;
  logic [2:0]    b_cnt;
`ifdef PACED_FIFO_ERR_FLAGS_EN
  logic          a_ovf, a_udf, b_ovf, b_udf;
`endif

  paced_ring_fifo #(.DEPTH(5), .DATA_WIDTH(DW), .GAP(0)) u_a (
    .clk_in          (clk),
    .rst_in          (rst),
    .data_valid_in   (a_vin),
    .data_in         (a_din),
    .ready_out       (a_rdy),
    .data_out        (a_dout),
    .data_valid_out  (a_vout),
    .receiver_ready  (a_rr),
    .full_out        (a_full),
    .empty_out       (a_empty),
    .almost_full_out (a_af),
    .count_out       (a_cnt)
`ifdef PACED_FIFO_ERR_FLAGS_EN
    ,
    .overflow_out    (a_ovf),
    .underflow_out   (a_udf)
`endif
  );

  paced_ring_fifo #(.DEPTH(5), .DATA_WIDTH(DW), .GAP(3)) u_b (
    .clk_in          (clk),
    .rst_in          (rst),
    .data_valid_in   (b_vin),
    .data_in         (b_din),
    .ready_out       (b_rdy),
    .data_out        (b_dout),
    .data_valid_out  (b_vout),
    .receiver_ready  (b_rr),
    .full_out        (b_full),
    .empty_out       (b_empty),
    .almost_full_out (b_af),
    .count_out       (b_cnt)
`ifdef PACED_FIFO_ERR_FLAGS_EN
    ,
    .overflow_out    (b_ovf),
    .underflow_out   (b_udf)
`endif
  );

  int vecs = 0;
  int errs = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic [DW-1:0] q[$];
  int pushed, popped, cyc;
  logic do_push, do_pop, exp_v;

  initial begin
    rst = 1'b1;
    a_vin = 1'b0; a_din = '0; a_rr = 1'b0;
    b_vin = 1'b0; b_din = '0; b_rr = 1'b0;
    @(negedge clk);
    @(negedge clk);

    // Reset values
    chk("rst count", a_cnt, 0);
    chk("rst empty", a_empty, 1);
    chk("rst full", a_full, 0);
    chk("rst afull", a_af, 0);
    chk("rst valid", a_vout, 0);
    chk("rst data", a_dout, 0);
    chk("rst ready", a_rdy, 1);
    chk("rst b valid", b_vout, 0);
    rst = 1'b0;
    @(negedge clk);

    // Single word, one-cycle latency
    a_vin = 1'b1; a_din = 8'hA5; a_rr = 1'b1;
    @(negedge clk);
    a_vin = 1'b0;
    chk("single valid", a_vout, 1);
    chk("single data", a_dout, 8'hA5);
    chk("single count1", a_cnt, 1);
    chk("single empty0", a_empty, 0);
    @(negedge clk);
    chk("single valid0", a_vout, 0);
    chk("single count0", a_cnt, 0);
    chk("single empty1", a_empty, 1);

    // Fill to full, drop a 6th push, drain in order
    a_rr = 1'b0;
    for (int i = 0; i < 5; i++) begin
      a_vin = 1'b1; a_din = DW'(8'h10 + i);
      @(negedge clk);
    end
    a_vin = 1'b0;
    chk("fill full", a_full, 1);
    chk("fill ready", a_rdy, 0);
    chk("fill count", a_cnt, 5);
    chk("fill afull", a_af, 1);
    a_vin = 1'b1; a_din = 8'hEE;
    @(negedge clk);
    a_vin = 1'b0;
    chk("drop count", a_cnt, 5);
    chk("drop full", a_full, 1);
`ifdef PACED_FIFO_ERR_FLAGS_EN
    chk("drop overflow", a_ovf, 1);
`endif
    a_rr = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("drain valid", a_vout, 1);
      chk("drain data", a_dout, 32'h10 + i);
      @(negedge clk);
    end
    chk("drain end valid", a_vout, 0);
    chk("drain end empty", a_empty, 1);
`ifdef PACED_FIFO_ERR_FLAGS_EN
    chk("no underflow", a_udf, 0);
    @(negedge clk);
    chk("underflow", a_udf, 1);
`endif
    a_rr = 1'b0;

    // Full FIFO with push and pop on the same edge
    for (int i = 0; i < 5; i++) begin
      a_vin = 1'b1; a_din = DW'(8'h20 + i);
      @(negedge clk);
    end
    a_din = 8'h25; a_rr = 1'b1;
    @(negedge clk);
    chk("fullpp count", a_cnt, 4);
    chk("fullpp full", a_full, 0);
    chk("fullpp data", a_dout, 8'h21);
    a_rr = 1'b0;
    @(negedge clk);
    a_vin = 1'b0;
    chk("fullpp count2", a_cnt, 5);
    chk("fullpp full2", a_full, 1);
    a_rr = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("fullpp drain", a_dout, 32'h21 + i);
      @(negedge clk);
    end
    chk("fullpp empty", a_empty, 1);
    a_rr = 1'b0;

    // Random valid/ready stream against a queue model
    pushed = 0; popped = 0; cyc = 0;
    while (popped < 23 && cyc < 2000) begin
      if (!(a_vin && !a_rdy)) begin
        if (pushed < 23 && $urandom_range(0, 99) < 60) begin
          a_vin = 1'b1; a_din = DW'(8'h60 + pushed);
        end else begin
          a_vin = 1'b0;
        end
      end
      a_rr = ($urandom_range(0, 99) < 50);
      do_push = a_vin && a_rdy;
      do_pop  = a_vout && a_rr;
      if (do_pop) begin
        if (q.size() == 0) begin
          chk("stream spurious", a_vout, 0);
        end else begin
          chk("stream data", a_dout, q[0]);
          void'(q.pop_front());
          popped++;
        end
      end
      if (do_push) begin
        q.push_back(a_din);
        pushed++;
      end
      @(negedge clk);
      cyc++;
      chk("stream count", a_cnt, q.size());
    end
    a_vin = 1'b0; a_rr = 1'b0;
    chk("stream complete", popped, 23);

    // Paced output with GAP=3
    for (int i = 0; i < 4; i++) begin
      b_vin = 1'b1; b_din = DW'(8'h30 + i);
      @(negedge clk);
    end
    b_vin = 1'b0;
    chk("gap preload", b_cnt, 4);
    b_rr = 1'b1;
    for (int i = 0; i < 16; i++) begin
      exp_v = (i % 4 == 0);
      chk("gap valid", b_vout, exp_v);
      if (exp_v) chk("gap data", b_dout, 32'h30 + i / 4);
      @(negedge clk);
    end
    chk("gap empty", b_empty, 1);
    chk("gap count", b_cnt, 0);
    b_rr = 1'b0;

    // Asynchronous reset between edges
    for (int i = 0; i < 3; i++) begin
      a_vin = 1'b1; a_din = DW'(8'h40 + i);
      @(negedge clk);
    end
    a_vin = 1'b0;
    chk("pre-rst data", a_dout, 8'h40);
    chk("pre-rst count", a_cnt, 3);
    #2 rst = 1'b1;
    #1;
    chk("arst valid", a_vout, 0);
    chk("arst data", a_dout, 0);
    chk("arst count", a_cnt, 0);
    chk("arst empty", a_empty, 1);
    chk("arst full", a_full, 0);
    chk("arst afull", a_af, 0);
`ifdef PACED_FIFO_ERR_FLAGS_EN
    chk("arst overflow", a_ovf, 0);
    chk("arst underflow", a_udf, 0);
`endif
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    a_vin = 1'b1; a_din = 8'h50;
    @(negedge clk);
    a_din = 8'h51;
    @(negedge clk);
    a_vin = 1'b0; a_rr = 1'b1;
    chk("post-rst valid", a_vout, 1);
    chk("post-rst first", a_dout, 8'h50);
    @(negedge clk);
    chk("post-rst second", a_dout, 8'h51);
    @(negedge clk);
    chk("post-rst empty", a_vout, 0);
    a_rr = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
